// File: rtl/pipeline_wb_checker_if.sv
// Bundle of the checker's table-load, run-control, writeback and result signals.
// The master side drives the stimulus; the slave side is the checker itself.
interface pipeline_wb_checker_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = 3
);
  logic             exp_wen;
  logic [IDX_W-1:0] exp_idx;
  logic [4:0]       exp_rd;
  logic [XLEN-1:0]  exp_data;
  logic [IDX_W:0]   num_checks;
  logic             start;
  logic             wb_wen;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       err_code;
  logic [IDX_W-1:0] fail_idx;
  logic [XLEN-1:0]  fail_data;
  logic [IDX_W:0]   match_count;

  modport master (
    output exp_wen, exp_idx, exp_rd, exp_data, num_checks, start, wb_wen, wb_rd, wb_data,
    input  busy, done, pass, err_code, fail_idx, fail_data, match_count
  );

  modport slave (
    input  exp_wen, exp_idx, exp_rd, exp_data, num_checks, start, wb_wen, wb_rd, wb_data,
    output busy, done, pass, err_code, fail_idx, fail_data, match_count
  );
endinterface

// File: rtl/pipeline_wb_checker.sv
// Compares the pipeline's in-order register writebacks against a preloaded table of
// expected (rd, data) pairs and reports pass, first mismatch, timeout or bad config.
module pipeline_wb_checker #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_CHECKS     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned IDX_W          = $clog2(NUM_CHECKS)
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_wb_checker_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W:0]  NumMax     = NUM_CHECKS[IDX_W:0];
  localparam logic [CntW-1:0] TimeoutVal = TIMEOUT_CYCLES[CntW-1:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrMismatch = 2'd1,
    ErrTimeout  = 2'd2,
    ErrConfig   = 2'd3
  } err_e;

  state_e           state_q, state_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [IDX_W:0]   mc_q, mc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  err_e             err_q, err_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [XLEN-1:0]  fdata_q, fdata_d;

  logic [4:0]       tab_rd_q   [NUM_CHECKS];
  logic [XLEN-1:0]  tab_data_q [NUM_CHECKS];

  logic [4:0]       cur_rd;
  logic [XLEN-1:0]  cur_data;
  logic             wb_hit;
  logic             entry_ok;
  logic [IDX_W:0]   mc_inc;
  logic [CntW-1:0]  cnt_inc;
  logic             finished;

  // The entry under test is always the one indexed by the running match count.
  assign cur_rd   = tab_rd_q[mc_q[IDX_W-1:0]];
  assign cur_data = tab_data_q[mc_q[IDX_W-1:0]];
  assign wb_hit   = bus.wb_wen && (bus.wb_rd != 5'd0);
  assign entry_ok = (cur_rd == bus.wb_rd) && (cur_data == bus.wb_data);
  assign mc_inc   = mc_q + 1'b1;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    mc_d     = mc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fdata_d  = fdata_q;
    finished = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          num_d   = bus.num_checks;
          mc_d    = '0;
          cnt_d   = '0;
          fidx_d  = '0;
          fdata_d = '0;
          err_d   = ErrNone;
          if (bus.num_checks == '0) begin
            state_d = StDone;
          end else if (bus.num_checks > NumMax) begin
            state_d = StDone;
            err_d   = ErrConfig;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        cnt_d = cnt_inc;
        if (wb_hit && entry_ok) begin
          mc_d = mc_inc;
          if (mc_inc == num_q) begin
            state_d  = StDone;
            finished = 1'b1;
          end
        end else if (wb_hit) begin
          state_d  = StDone;
          finished = 1'b1;
          err_d    = ErrMismatch;
          fidx_d   = mc_q[IDX_W-1:0];
          fdata_d  = bus.wb_data;
        end
        // A match or mismatch on the last allowed cycle wins over the timeout.
        if (!finished && (cnt_inc == TimeoutVal)) begin
          state_d = StDone;
          err_d   = ErrTimeout;
          fidx_d  = mc_d[IDX_W-1:0];
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      num_q   <= '0;
      mc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= ErrNone;
      fidx_q  <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
    end
  end

  // Table loads are locked out while a run is comparing against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tab_rd_q[i]   <= '0;
        tab_data_q[i] <= '0;
      end
    end else if (bus.exp_wen && (state_q != StRun)) begin
      tab_rd_q[bus.exp_idx]   <= bus.exp_rd;
      tab_data_q[bus.exp_idx] <= bus.exp_data;
    end
  end

  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.pass        = (state_q == StDone) && (err_q == ErrNone);
  assign bus.err_code    = err_q;
  assign bus.fail_idx    = fidx_q;
  assign bus.fail_data   = fdata_q;
  assign bus.match_count = mc_q;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(bus.busy && bus.done));
  a_pass_needs_done: assert property (@(posedge clk) disable iff (rst) bus.pass |-> bus.done);
  a_mc_bounded: assert property (@(posedge clk) disable iff (rst) bus.busy |-> mc_q < num_q);

endmodule

// File: tb/tb_pipeline_wb_checker.sv
// Randomised scoreboard bench for pipeline_wb_checker: a run-level reference model
// predicts each run's result, a negedge monitor pops and compares when done appears.
module tb_pipeline_wb_checker;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NC   = 8;
  localparam int unsigned TO   = 20;
  localparam int unsigned IW   = 3;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [1:0]  err;
    logic        pass;
    logic [2:0]  fidx;
    logic [31:0] fdata;
    logic [3:0]  mc;
    int          cycles;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [4:0]  m_rd   [NC];
  logic [31:0] m_data [NC];
  wb_t         sched[$];
  res_t        sb[$];

  pipeline_wb_checker_if #(.XLEN(XLEN), .IDX_W(IW)) bus ();

  pipeline_wb_checker #(
    .XLEN(XLEN),
    .NUM_CHECKS(NC),
    .TIMEOUT_CYCLES(TO),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic [1:0] err, input logic pass, input logic [2:0] fidx,
                              input logic [31:0] fdata, input logic [3:0] mc, input int cyc);
    res_t r;
    r.err = err; r.pass = pass; r.fidx = fidx; r.fdata = fdata; r.mc = mc; r.cycles = cyc;
    return r;
  endfunction

  // Walks the writeback schedule one RUN cycle at a time against the expected list.
  function automatic res_t model(input int n);
    int  m;
    wb_t w;
    m = 0;
    if (n == 0) return mk(2'd0, 1'b1, 3'd0, 32'd0, 4'd0, 0);
    if (n > NC) return mk(2'd3, 1'b0, 3'd0, 32'd0, 4'd0, 0);
    for (int t = 0; t < TO; t++) begin
      if (t < sched.size()) w = sched[t];
      else w = '{wen: 1'b0, rd: 5'd0, data: 32'd0};
      if (w.wen && w.rd != 5'd0) begin
        if (w.rd == m_rd[m] && w.data == m_data[m]) begin
          m++;
          if (m == n) return mk(2'd0, 1'b1, 3'd0, 32'd0, 4'(m), t + 1);
        end else begin
          return mk(2'd1, 1'b0, 3'(m), w.data, 4'(m), t + 1);
        end
      end
    end
    return mk(2'd2, 1'b0, 3'(m), 32'd0, 4'(m), TO);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic [4:0] rd, input logic [31:0] data);
    bus.exp_wen  = 1'b1;
    bus.exp_idx  = IW'(idx);
    bus.exp_rd   = rd;
    bus.exp_data = data;
    m_rd[idx]    = rd;
    m_data[idx]  = data;
    tick();
    bus.exp_wen  = 1'b0;
  endtask

  task automatic run(input int n, input bit ws, input int ws_idx, input logic [4:0] ws_rd,
                     input logic [31:0] ws_data, input bit rw, input bit hand_en,
                     input res_t hand);
    bus.start      = 1'b1;
    bus.num_checks = 4'(n);
    bus.wb_wen     = 1'b0;
    if (ws) begin
      bus.exp_wen      = 1'b1;
      bus.exp_idx      = IW'(ws_idx);
      bus.exp_rd       = ws_rd;
      bus.exp_data     = ws_data;
      m_rd[ws_idx]     = ws_rd;
      m_data[ws_idx]   = ws_data;
    end
    sb.push_back(hand_en ? hand : model(n));
    tick();
    bus.start   = 1'b0;
    bus.exp_wen = 1'b0;
    for (int t = 0; t < TO + 2; t++) begin
      if (t < sched.size()) begin
        bus.wb_wen  = sched[t].wen;
        bus.wb_rd   = sched[t].rd;
        bus.wb_data = sched[t].data;
      end else begin
        bus.wb_wen = 1'b0;
      end
      // Table write attempted while the checker is comparing; must not land.
      bus.exp_wen = 1'b0;
      if (rw && t == 1 && bus.busy) begin
        bus.exp_wen  = 1'b1;
        bus.exp_idx  = IW'($urandom_range(0, NC - 1));
        bus.exp_rd   = 5'($urandom);
        bus.exp_data = $urandom;
      end
      tick();
    end
    bus.wb_wen  = 1'b0;
    bus.exp_wen = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    check("drain", 64'(sb.size()), 64'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic push_wb(input logic wen, input logic [4:0] rd, input logic [31:0] data);
    wb_t w;
    w.wen = wen; w.rd = rd; w.data = data;
    sched.push_back(w);
  endtask

  task automatic load_abc();
    write_entry(0, 5'd1, 32'd5);
    write_entry(1, 5'd2, 32'd10);
    write_entry(2, 5'd3, 32'hFFFF_FFFF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_pass"}, 64'(bus.pass), 64'd0);
    check({tag, "_err"}, 64'(bus.err_code), 64'd0);
    check({tag, "_fidx"}, 64'(bus.fail_idx), 64'd0);
    check({tag, "_fdata"}, 64'(bus.fail_data), 64'd0);
    check({tag, "_mc"}, 64'(bus.match_count), 64'd0);
  endtask

  // Monitor: a run result is presented when done rises out of RUN or right after start.
  logic busy_prev = 1'b0;
  logic start_prev = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      busy_prev  = 1'b0;
      start_prev = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done && (busy_prev || start_prev)) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("err_code", 64'(bus.err_code), 64'(e.err));
          check("pass", 64'(bus.pass), 64'(e.pass));
          check("fail_idx", 64'(bus.fail_idx), 64'(e.fidx));
          check("fail_data", 64'(bus.fail_data), 64'(e.fdata));
          check("match_count", 64'(bus.match_count), 64'(e.mc));
          check("run_cycles", 64'(busy_cnt), 64'(e.cycles));
        end
      end
      if (bus.start) busy_cnt = 0;
      busy_prev  = bus.busy;
      start_prev = bus.start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    res_t none;
    int   n, bad_at, stop_at, sel;
    wb_t  w;
    none = mk(2'd0, 1'b0, 3'd0, 32'd0, 4'd0, 0);
    for (int i = 0; i < NC; i++) begin
      m_rd[i] = '0;
      m_data[i] = '0;
    end
    bus.exp_wen = 1'b0; bus.exp_idx = '0; bus.exp_rd = '0; bus.exp_data = '0;
    bus.num_checks = '0; bus.start = 1'b0;
    bus.wb_wen = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Matching sequence passes.
    load_abc();
    sched.delete();
    push_wb(1, 5'd1, 32'd5); push_wb(1, 5'd2, 32'd10); push_wb(1, 5'd3, 32'hFFFF_FFFF);
    run(3, 0, 0, 0, 0, 0, 1, mk(2'd0, 1'b1, 3'd0, 32'd0, 4'd3, 3));

    // Data mismatch on the second entry.
    sched.delete();
    push_wb(1, 5'd1, 32'd5); push_wb(1, 5'd2, 32'd11);
    run(3, 0, 0, 0, 0, 0, 1, mk(2'd1, 1'b0, 3'd1, 32'd11, 4'd1, 2));

    // x0 writebacks interleaved are ignored.
    sched.delete();
    push_wb(1, 5'd0, 32'h1234); push_wb(1, 5'd1, 32'd5); push_wb(1, 5'd0, 32'h1234);
    push_wb(0, 5'd7, 32'd0); push_wb(1, 5'd2, 32'd10); push_wb(1, 5'd0, 32'h1234);
    push_wb(1, 5'd3, 32'hFFFF_FFFF);
    run(3, 0, 0, 0, 0, 0, 1, mk(2'd0, 1'b1, 3'd0, 32'd0, 4'd3, 7));

    // Timeout after a single match.
    sched.delete();
    push_wb(1, 5'd1, 32'd5);
    run(3, 0, 0, 0, 0, 0, 1, mk(2'd2, 1'b0, 3'd1, 32'd0, 4'd1, TO));

    // Bad config and empty run.
    sched.delete();
    run(NC + 1, 0, 0, 0, 0, 0, 1, mk(2'd3, 1'b0, 3'd0, 32'd0, 4'd0, 0));
    run(0, 0, 0, 0, 0, 0, 1, mk(2'd0, 1'b1, 3'd0, 32'd0, 4'd0, 0));

    // Table write in the start cycle is visible to that run.
    sched.delete();
    push_wb(1, 5'd7, 32'h77);
    run(1, 1, 0, 5'd7, 32'h77, 0, 1, mk(2'd0, 1'b1, 3'd0, 32'd0, 4'd1, 1));

    // Asynchronous reset mid-run after one match.
    load_abc();
    bus.start = 1'b1; bus.num_checks = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.wb_wen = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    tick();
    bus.wb_wen = 1'b0;
    check("pre_reset_mc", 64'(bus.match_count), 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_rd[i] = '0;
      m_data[i] = '0;
    end
    // Cleared table: entry 0 is now (x0, 0), so a real writeback mismatches.
    sched.delete();
    push_wb(1, 5'd1, 32'd5);
    run(1, 0, 0, 0, 0, 0, 1, mk(2'd1, 1'b0, 3'd0, 32'd5, 4'd0, 1));
    load_abc();
    sched.delete();
    push_wb(1, 5'd1, 32'd5); push_wb(1, 5'd2, 32'd10); push_wb(1, 5'd3, 32'hFFFF_FFFF);
    run(3, 0, 0, 0, 0, 0, 1, mk(2'd0, 1'b1, 3'd0, 32'd0, 4'd3, 3));

    // Randomised runs against the reference model.
    for (int r = 0; r < 40; r++) begin
      if ($urandom % 3 != 0) begin
        for (int i = 0; i < NC; i++) begin
          write_entry(i, ($urandom % 16 == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                      ($urandom % 4 == 0) ? 32'($urandom % 8) : $urandom);
        end
      end
      sel = $urandom % 12;
      if (sel == 0) n = 0;
      else if (sel == 1) n = NC + 1;
      else n = $urandom_range(1, NC);
      bad_at  = ($urandom % 4 == 0 && n >= 1) ? $urandom_range(0, n - 1) : -1;
      stop_at = ($urandom % 6 == 0 && n >= 1) ? $urandom_range(0, n - 1) : n;
      sched.delete();
      for (int e = 0; e < n && e < NC; e++) begin
        if (e == stop_at) break;
        repeat ($urandom % 3) begin
          if ($urandom % 2 == 0) push_wb(1, 5'd0, $urandom);
          else push_wb(0, 5'($urandom), $urandom);
        end
        w.wen = 1'b1; w.rd = m_rd[e]; w.data = m_data[e];
        if (e == bad_at) begin
          if ($urandom % 2 == 0) w.rd = w.rd ^ 5'($urandom_range(1, 31));
          else w.data = w.data ^ (32'd1 << ($urandom % 32));
        end
        sched.push_back(w);
      end
      repeat ($urandom % 3) push_wb(1, 5'($urandom), $urandom);
      run(n, ($urandom % 4 == 0), $urandom_range(0, NC - 1), 5'($urandom_range(1, 31)),
          $urandom, ($urandom % 3 == 0), 0, none);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_wb_checker.md
PIPELINE_WB_CHECKER -- requirements
Module: pipeline_wb_checker

Interface
REQ-001 Parameter XLEN, 32, datapath and writeback data width.
REQ-002 Parameter NUM_CHECKS, 8, depth of expected-result table (power of two, >= 2).
REQ-003 Parameter TIMEOUT_CYCLES, 1000, max cycles in RUN before timeout (>= 1).
REQ-004 Parameter IDX_W, $clog2(NUM_CHECKS), table index width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 exp_wen  input  1  table write strobe, honoured only in IDLE/DONE states.
REQ-008 exp_idx  input  IDX_W  table write index.
REQ-009 exp_rd  input  5  expected destination register for entry.
REQ-010 exp_data  input  XLEN  expected writeback value for entry.
REQ-011 num_checks  input  IDX_W+1  entries to check, sampled on start.
REQ-012 start  input  1  one-cycle pulse starting a check run.
REQ-013 wb_wen  input  1  pipeline writeback enable (WB stage).
REQ-014 wb_rd  input  5  pipeline writeback register address.
REQ-015 wb_data  input  XLEN  pipeline writeback data.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  high in DONE, held until next start.
REQ-018 pass  output  1  valid when done; high only for err_code 0.
REQ-019 err_code  output  2  0 none, 1 mismatch, 2 timeout, 3 bad config.
REQ-020 fail_idx  output  IDX_W  entry index at first failure.
REQ-021 fail_data  output  XLEN  wb_data captured at mismatch; 0 otherwise.
REQ-022 match_count  output  IDX_W+1  entries matched so far in current run.

Function
REQ-023 FSM states IDLE, RUN, DONE; IDLE->RUN on start with 1 <= num_checks <= NUM_CHECKS.
REQ-024 start with num_checks 0: DONE next cycle, pass=1, err_code 0, match_count 0.
REQ-025 start with num_checks > NUM_CHECKS: DONE next cycle, pass=0, err_code 3.
REQ-026 start in DONE behaves as in IDLE; start in RUN ignored.
REQ-027 On entering RUN: match_count, cycle counter, fail_idx, fail_data cleared to 0; table contents retained.
REQ-028 In RUN, writebacks with wb_wen=1 and wb_rd=0 ignored (x0 writes are not checked).
REQ-029 In RUN, qualifying writeback compared in order to entry match_count: rd and data both equal -> match_count+1 next cycle.
REQ-030 Any rd or data inequality -> DONE next cycle, err_code 1, fail_idx=match_count, fail_data=wb_data.
REQ-031 match_count reaching num_checks -> DONE in that same update, pass=1; later writebacks not examined.
REQ-032 Cycle counter increments each RUN cycle; reaching TIMEOUT_CYCLES with no completion -> DONE, err_code 2, fail_idx=match_count.
REQ-033 Match/mismatch on the timeout cycle takes priority over timeout.
REQ-034 exp_wen in RUN ignored; exp_wen same cycle as start in IDLE writes table before run uses it.
REQ-035 Table read is combinational from registered entries; check latency 1 cycle from wb_wen to outputs.

Reset
REQ-036 rst asserted: state IDLE, busy 0, done 0, pass 0, err_code 0, fail_idx 0, fail_data 0, match_count 0, counter 0, all table entries rd 0 / data 0.
REQ-037 rst mid-RUN aborts run immediately; no done pulse produced.

Verification
REQ-038 Load {x1=5, x2=10, x3=0xFFFFFFFF}, num_checks 3, drive matching writebacks -> done=1, pass=1, match_count 3.
REQ-039 Same table, second writeback x2=11 -> done, err_code 1, fail_idx 1, fail_data 11, match_count 1.
REQ-040 Interleave wb_rd=0 writes with data 0x1234 between matches -> ignored, pass=1.
REQ-041 TIMEOUT_CYCLES=20, one matching writeback only -> done after 20 RUN cycles, err_code 2, fail_idx 1.
REQ-042 start with num_checks NUM_CHECKS+1 -> err_code 3; num_checks 0 -> pass=1 next cycle.
REQ-043 Assert rst during RUN after 1 match -> all outputs 0 asynchronously, restart passes normally.
